// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receive and transmit paths: state encodings,
// default timing/depth parameters and a constant-foldable clog2.
package rs232_pkg;

    localparam int DEFAULT_CLK_DIV = 434;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DATA_BITS       = 8;

    localparam logic [2:0] ST_ARM   = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rs232_rx_fifo.sv
// Synchronous FIFO buffering received bytes; a push on a full FIFO only lands
// when a pop happens in the same cycle.
module rs232_rx_fifo
    import rs232_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DATA_BITS
) (
    input  logic                      CLK_50MHZ,
    input  logic                      RST,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         head,
    output logic                      empty,
    output logic                      full,
    output logic [clog2(DEPTH):0]     count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == OCC_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero when empty so the output has a defined reset value.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK_50MHZ) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rs232_rx.sv
// 8N1 RS-232 receiver: RX synchronizer, mid-bit sampling timer and framing FSM,
// feeding completed bytes into a small FIFO with flow control back to the sender.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       RX,
    input  logic       TRG_READ,
    output logic [7:0] DATA_OUT,
    output logic       EMPTY,
    output logic       FLOW,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int CNT_W = clog2(CLK_DIV);
    localparam int OCC_W = clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);

    logic             rx_meta;
    logic             rx_s;
    logic             rx_d;
    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             expiry;
    logic             stop_sample;
    logic             push_req;
    logic             fifo_full;
    logic [OCC_W-1:0] occ;

    // Synchronizer resets low so ARM only leaves once a genuine idle-high line is seen.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            rx_d    <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign expiry      = (bit_cnt == '0);
    assign stop_sample = (state == ST_STOP) && expiry;
    assign push_req    = stop_sample && rx_s;

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state   <= ST_ARM;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_ARM: begin
                    if (rx_s) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!rx_s && rx_d) begin
                        bit_cnt <= HALF_LOAD;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (expiry) begin
                        if (!rx_s) begin
                            bit_cnt <= FULL_LOAD;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (expiry) begin
                        bit_cnt <= FULL_LOAD;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (expiry) state <= ST_IDLE;
                    else bit_cnt <= bit_cnt - CNT_W'(1);
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if ((state == ST_DATA) && expiry) shift[bit_idx] <= rx_s;
    end

    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= stop_sample && !rx_s;
            OVERRUN   <= push_req && fifo_full && !TRG_READ;
        end
    end

    assign BUSY = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign FLOW = (occ < OCC_W'(DEPTH - 1));

    rs232_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .push      (push_req),
        .pop       (TRG_READ),
        .wdata     (shift),
        .head      (DATA_OUT),
        .empty     (EMPTY),
        .full      (fifo_full),
        .count     (occ)
    );

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx at CLK_DIV=16, DEPTH=4: table of single frames plus
// hand-written back-to-back, glitch, overflow and mid-frame reset sequences.
module tb_rs232_rx;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 4;

    logic       CLK_50MHZ = 1'b0;
    logic       RST;
    logic       RX;
    logic       TRG_READ;
    logic [7:0] DATA_OUT;
    logic       EMPTY;
    logic       FLOW;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int long_cnt = 0;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    rs232_rx #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .RX        (RX),
        .TRG_READ  (TRG_READ),
        .DATA_OUT  (DATA_OUT),
        .EMPTY     (EMPTY),
        .FLOW      (FLOW),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .BUSY      (BUSY)
    );

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    always @(negedge CLK_50MHZ) begin
        if (FRAME_ERR) fe_cnt++;
        if (OVERRUN) ov_cnt++;
        if ((FRAME_ERR && fe_prev) || (OVERRUN && ov_prev)) long_cnt++;
        fe_prev = FRAME_ERR;
        ov_prev = OVERRUN;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        RX = 1'b0;
        repeat (CLK_DIV) @(negedge CLK_50MHZ);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (CLK_DIV) @(negedge CLK_50MHZ);
        end
        RX = stop_bit;
        repeat (CLK_DIV) @(negedge CLK_50MHZ);
        RX = 1'b1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s actual=pop required=no_expected_entry", name);
            return;
        end
        exp = sb.pop_front();
        check({name, "_empty"}, EMPTY, 0);
        check(name, DATA_OUT, exp);
        TRG_READ = 1'b1;
        @(negedge CLK_50MHZ);
        TRG_READ = 1'b0;
    endtask

    initial begin
        int n;
        int fe0;
        int ov0;

        vecs[0] = '{8'h03, 1'b1, 0};
        vecs[1] = '{8'hA5, 1'b0, 1};
        vecs[2] = '{8'h5A, 1'b1, 0};
        vecs[3] = '{8'hFF, 1'b1, 0};
        vecs[4] = '{8'h00, 1'b1, 0};
        vecs[5] = '{8'h80, 1'b1, 0};

        RST = 1'b0;
        RX = 1'b1;
        TRG_READ = 1'b0;
        repeat (3) @(negedge CLK_50MHZ);
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_empty", EMPTY, 1);
        check("rst_flow", FLOW, 1);
        check("rst_frame_err", FRAME_ERR, 0);
        check("rst_overrun", OVERRUN, 0);
        check("rst_busy", BUSY, 0);
        RST = 1'b1;
        repeat (6) @(negedge CLK_50MHZ);

        // First frame: EMPTY falls 155 negedges after the start bit is driven
        // (2 synchronizer cycles to t0, then t0+153).
        sb.push_back(8'h03);
        n = 0;
        fork
            send_frame(8'h03, 1'b1);
            begin
                while (EMPTY && n < 400) begin
                    @(negedge CLK_50MHZ);
                    n++;
                end
            end
        join
        check("first_latency", n, 155);
        check("first_busy_idle", BUSY, 0);
        pop_check("first_pop");
        check("first_empty_after", EMPTY, 1);

        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            if (vecs[i].stop) sb.push_back(vecs[i].d);
            send_frame(vecs[i].d, vecs[i].stop);
            repeat (4) @(negedge CLK_50MHZ);
            check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
            if (vecs[i].stop) pop_check($sformatf("vec%0d_data", i));
            else check($sformatf("vec%0d_empty", i), EMPTY, 1);
        end

        sb.push_back(8'h03);
        sb.push_back(8'h06);
        send_frame(8'h03, 1'b1);
        send_frame(8'h06, 1'b1);
        repeat (4) @(negedge CLK_50MHZ);
        check("b2b_flow", FLOW, 1);
        pop_check("b2b_pop0");
        pop_check("b2b_pop1");
        check("b2b_empty", EMPTY, 1);

        // 4-cycle glitch: t0 is negedge 2, START sample returns to IDLE by t0+9.
        fe0 = fe_cnt;
        RX = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK_50MHZ);
            if (i == 4) RX = 1'b1;
            if (i == 5) check("glitch_busy_start", BUSY, 1);
            if (i == 10) check("glitch_busy_t0p8", BUSY, 1);
            if (i == 11) check("glitch_busy_t0p9", BUSY, 0);
        end
        repeat (20) @(negedge CLK_50MHZ);
        check("glitch_frame_err", fe_cnt - fe0, 0);
        check("glitch_empty", EMPTY, 1);

        ov0 = ov_cnt;
        for (int v = 1; v <= 5; v++) begin
            if (v <= DEPTH) sb.push_back(8'(v));
            send_frame(8'(v), 1'b1);
            if (v == 2) check("ovf_flow_after2", FLOW, 1);
            if (v == 3) check("ovf_flow_after3", FLOW, 0);
        end
        repeat (4) @(negedge CLK_50MHZ);
        check("ovf_overrun", ov_cnt - ov0, 1);
        for (int v = 1; v <= 4; v++) pop_check($sformatf("ovf_pop%0d", v));
        check("ovf_empty", EMPTY, 1);
        check("ovf_flow_drained", FLOW, 1);

        // Pop lands in the same cycle as the 5th push (stop sample at negedge 154).
        ov0 = ov_cnt;
        for (int v = 1; v <= 4; v++) begin
            sb.push_back(8'(v));
            send_frame(8'(v), 1'b1);
        end
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (154) @(negedge CLK_50MHZ);
                pop_check("coin_pop1");
                sb.push_back(8'h05);
            end
        join
        repeat (4) @(negedge CLK_50MHZ);
        check("coin_overrun", ov_cnt - ov0, 0);
        for (int v = 2; v <= 5; v++) pop_check($sformatf("coin_pop%0d", v));
        check("coin_empty", EMPTY, 1);

        // Leave a byte queued, then reset during data bit 4 while RX is low.
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (4) @(negedge CLK_50MHZ);
        check("prereset_empty", EMPTY, 0);
        fork
            send_frame(8'h0F, 1'b1);
            begin
                repeat (85) @(negedge CLK_50MHZ);
                RST = 1'b0;
                sb.delete();
                @(negedge CLK_50MHZ);
                check("midrst_empty", EMPTY, 1);
                check("midrst_busy", BUSY, 0);
                check("midrst_data_out", DATA_OUT, 8'h00);
                repeat (4) @(negedge CLK_50MHZ);
                RST = 1'b1;
                repeat (10) @(negedge CLK_50MHZ);
                check("arm_busy", BUSY, 0);
            end
        join
        repeat (10) @(negedge CLK_50MHZ);
        check("postrst_empty", EMPTY, 1);
        check("postrst_busy", BUSY, 0);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge CLK_50MHZ);
        pop_check("postrst_pop");
        check("postrst_empty_after", EMPTY, 1);

        check("pulse_width", long_cnt, 0);
        check("frame_err_total", fe_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
